// File: rtl/sensor_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module      : sensor_debouncer_if
// Description : Hit-event handshake between the sensor debouncer (producer)
//               and the scoring / game control logic (consumer).
//   hit_valid  producer -> consumer  a hit event is pending
//   hit_addr   producer -> consumer  box code of pending hit, stable while valid
//   hit_ready  consumer -> producer  consumer accepts the hit this cycle
// Revision    : 1.0  initial release
// ============================================================================
interface sensor_debouncer_if #(
  parameter int WIDTH = 3
) ();
  logic             hit_valid;
  logic             hit_ready;
  logic [WIDTH-1:0] hit_addr;

  modport master (
    output hit_valid,
    output hit_addr,
    input  hit_ready
  );

  modport slave (
    input  hit_valid,
    input  hit_addr,
    output hit_ready
  );
endinterface
`default_nettype wire

// File: rtl/sensor_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : sensor_debouncer
// Description : Turns the raw asynchronous sensor code into a debounced code
//               and produces exactly one hit event per strike into a nonzero
//               code, delivered through a one-deep ready/valid register.
// Ports       :
//   CLOCK_50      in   system clock, rising edge
//   resetn        in   asynchronous active-low reset
//   sensor_raw    in   raw sensor code (asynchronous)
//   overrun_clr   in   synchronous clear of hit_overrun
//   sensor_clean  out  debounced sensor code
//   hit_overrun   out  sticky: a hit was dropped while one was pending
//   hit           master side of the hit handshake (valid/addr out, ready in)
// Revision    : 1.0  initial release
// ============================================================================
module sensor_debouncer #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [WIDTH-1:0]    sensor_raw,
  input  logic                overrun_clr,
  output logic [WIDTH-1:0]    sensor_clean,
  output logic                hit_overrun,
  sensor_debouncer_if.master  hit
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } state_t;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_clean;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_sat;
  logic             w_stable;
  logic             w_clean_upd;
  logic             r_upd_pulse;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_event;

  logic             r_hit_valid;
  logic [WIDTH-1:0] r_hit_addr;
  logic             r_overrun;
  logic             w_accept;
  logic             w_drop;

  // --------------------------------------------------------------------------
  // Synchronizer and debounce counter
  // --------------------------------------------------------------------------
  // The counter saturates at its terminal value instead of wrapping. The clean
  // code is taken on the edge where the count reaches the terminal value, so
  // the candidate has then been sampled unchanged on DEBOUNCE_CYCLES edges
  // (the load edge included).
  always_comb begin
    w_stable    = (r_sync2 == r_cand);
    w_cnt_sat   = (r_cnt == c_cnt_last) ? r_cnt : r_cnt + 1'b1;
    w_clean_upd = w_stable && (w_cnt_sat == c_cnt_last) && (r_cand != r_clean);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_clean     <= '0;
      r_upd_pulse <= 1'b0;
    end else begin
      r_sync1 <= sensor_raw;
      r_sync2 <= r_sync1;
      if (!w_stable) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= w_cnt_sat;
      end
      if (w_clean_upd) begin
        r_clean <= r_cand;
      end
      // Marks the cycle in which sensor_clean holds a freshly updated code.
      r_upd_pulse <= w_clean_upd;
    end
  end

  // --------------------------------------------------------------------------
  // Press FSM: follows sensor_clean, raises one event per new nonzero code
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_event      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_upd_pulse && (r_clean != '0)) begin
          w_event      = 1'b1;
          w_state_next = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (r_upd_pulse) begin
          if (r_clean == '0) begin
            w_state_next = ST_IDLE;
          end else begin
            // An update always carries a code different from the previous one.
            w_event = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // One-deep hit register with ready/valid handshake
  // --------------------------------------------------------------------------
  assign w_accept = r_hit_valid & hit.hit_ready;
  assign w_drop   = w_event & r_hit_valid & ~hit.hit_ready;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_hit_valid <= 1'b0;
      r_hit_addr  <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_event && (!r_hit_valid || w_accept)) begin
        r_hit_valid <= 1'b1;
        r_hit_addr  <= r_clean;
      end else if (w_accept) begin
        r_hit_valid <= 1'b0;
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign sensor_clean  = r_clean;
  assign hit_overrun   = r_overrun;
  assign hit.hit_valid = r_hit_valid;
  assign hit.hit_addr  = r_hit_addr;

endmodule
`default_nettype wire

// File: tb/tb_sensor_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_debouncer
// Description : Directed self-checking bench for sensor_debouncer with
//               DEBOUNCE_CYCLES = 4 (clean update 6 edges after a raw step,
//               hit_valid one edge later).
// Revision    : 1.0  initial release
// ============================================================================
module tb_sensor_debouncer;

  localparam int WIDTH = 3;

  logic             clk = 1'b0;
  logic             resetn;
  logic [WIDTH-1:0] sensor_raw;
  logic             overrun_clr;
  logic [WIDTH-1:0] sensor_clean;
  logic             hit_overrun;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] q_addr[$];
  logic             clean_nz_seen;

  always #5 clk = ~clk;

  sensor_debouncer_if #(.WIDTH(WIDTH)) hit_if ();

  sensor_debouncer #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .sensor_raw  (sensor_raw),
    .overrun_clr (overrun_clr),
    .sensor_clean(sensor_clean),
    .hit_overrun (hit_overrun),
    .hit         (hit_if.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; returns 1 time unit after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance n edges, logging every cycle with a pending hit.
  task automatic run_collect(input int n);
    repeat (n) begin
      tick(1);
      if (hit_if.hit_valid) q_addr.push_back(hit_if.hit_addr);
      if (sensor_clean != '0) clean_nz_seen = 1'b1;
    end
  endtask

  initial begin
    resetn           = 1'b0;
    sensor_raw       = '0;
    overrun_clr      = 1'b0;
    hit_if.hit_ready = 1'b0;
    clean_nz_seen    = 1'b0;

    // ---------------- reset state ----------------
    #1;
    check("rst_clean",   32'(sensor_clean),    32'h0);
    check("rst_valid",   32'(hit_if.hit_valid), 32'h0);
    check("rst_addr",    32'(hit_if.hit_addr),  32'h0);
    check("rst_overrun", 32'(hit_overrun),      32'h0);
    tick(2);
    resetn = 1'b1;

    // ---------------- 1: reset mid-count ----------------
    sensor_raw = 3'b101;
    tick(8);
    check("t1_pre_clean", 32'(sensor_clean),     32'h5);
    check("t1_pre_valid", 32'(hit_if.hit_valid), 32'h1);
    sensor_raw = 3'b000;
    tick(3);
    sensor_raw = 3'b101;
    #2 resetn = 1'b0;
    #1;
    check("t1_async_clean", 32'(sensor_clean),     32'h0);
    check("t1_async_valid", 32'(hit_if.hit_valid), 32'h0);
    check("t1_async_addr",  32'(hit_if.hit_addr),  32'h0);
    tick(2);
    resetn = 1'b1;
    tick(5);
    check("t1_edge5_clean", 32'(sensor_clean),     32'h0);
    tick(1);
    check("t1_edge6_clean", 32'(sensor_clean),     32'h5);
    check("t1_edge6_valid", 32'(hit_if.hit_valid), 32'h0);
    tick(1);
    check("t1_edge7_valid", 32'(hit_if.hit_valid), 32'h1);
    check("t1_edge7_addr",  32'(hit_if.hit_addr),  32'h5);
    hit_if.hit_ready = 1'b1;
    tick(1);
    check("t1_accept_valid", 32'(hit_if.hit_valid), 32'h0);
    hit_if.hit_ready = 1'b0;
    sensor_raw = 3'b000;
    tick(8);
    check("t1_release_clean", 32'(sensor_clean),     32'h0);
    check("t1_release_valid", 32'(hit_if.hit_valid), 32'h0);

    // ---------------- 2: glitch rejected ----------------
    q_addr.delete();
    clean_nz_seen = 1'b0;
    sensor_raw = 3'b010;
    tick(3);
    sensor_raw = 3'b000;
    run_collect(12);
    check("t2_glitch_clean_nz", 32'(clean_nz_seen), 32'h0);
    check("t2_glitch_hits",     32'(q_addr.size()), 32'h0);

    // ---------------- 3: hold then release ----------------
    hit_if.hit_ready = 1'b1;
    q_addr.delete();
    sensor_raw = 3'b011;
    run_collect(50);
    check("t3_hold_hits", 32'(q_addr.size()), 32'h1);
    if (q_addr.size() > 0) check("t3_hold_addr", 32'(q_addr[0]), 32'h3);
    check("t3_hold_clean", 32'(sensor_clean), 32'h3);
    sensor_raw = 3'b000;
    tick(5);
    check("t3_rel_edge5", 32'(sensor_clean), 32'h3);
    tick(1);
    check("t3_rel_edge6", 32'(sensor_clean), 32'h0);
    q_addr.delete();
    run_collect(10);
    check("t3_rel_hits", 32'(q_addr.size()), 32'h0);
    hit_if.hit_ready = 1'b0;

    // ---------------- 4: backpressure / overrun ----------------
    sensor_raw = 3'b001;
    tick(8);
    check("t4_first_valid",   32'(hit_if.hit_valid), 32'h1);
    check("t4_first_addr",    32'(hit_if.hit_addr),  32'h1);
    check("t4_first_overrun", 32'(hit_overrun),      32'h0);
    sensor_raw = 3'b110;
    tick(8);
    check("t4_second_clean",   32'(sensor_clean),     32'h6);
    check("t4_second_addr",    32'(hit_if.hit_addr),  32'h1);
    check("t4_second_valid",   32'(hit_if.hit_valid), 32'h1);
    check("t4_second_overrun", 32'(hit_overrun),      32'h1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    check("t4_clr_overrun", 32'(hit_overrun),      32'h0);
    check("t4_clr_valid",   32'(hit_if.hit_valid), 32'h1);
    hit_if.hit_ready = 1'b1;
    tick(1);
    check("t4_drain_valid", 32'(hit_if.hit_valid), 32'h0);
    hit_if.hit_ready = 1'b0;

    // ---------------- 5: accept and new event on same edge ----------------
    sensor_raw = 3'b000;
    tick(8);
    sensor_raw = 3'b001;
    tick(8);
    check("t5_pend_addr", 32'(hit_if.hit_addr), 32'h1);
    sensor_raw = 3'b100;
    tick(6);
    check("t5_upd_clean", 32'(sensor_clean),     32'h4);
    check("t5_upd_valid", 32'(hit_if.hit_valid), 32'h1);
    check("t5_upd_addr",  32'(hit_if.hit_addr),  32'h1);
    hit_if.hit_ready = 1'b1;
    tick(1);
    check("t5_same_valid",   32'(hit_if.hit_valid), 32'h1);
    check("t5_same_addr",    32'(hit_if.hit_addr),  32'h4);
    check("t5_same_overrun", 32'(hit_overrun),      32'h0);
    tick(1);
    check("t5_after_valid", 32'(hit_if.hit_valid), 32'h0);

    // ---------------- 6: code change while pressed ----------------
    q_addr.delete();
    sensor_raw = 3'b010;
    run_collect(12);
    sensor_raw = 3'b111;
    run_collect(12);
    check("t6_hits", 32'(q_addr.size()), 32'h2);
    if (q_addr.size() > 1) begin
      check("t6_addr0", 32'(q_addr[0]), 32'h2);
      check("t6_addr1", 32'(q_addr[1]), 32'h7);
    end
    check("t6_clean", 32'(sensor_clean), 32'h7);
    hit_if.hit_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
